serial_tx_frm: RTL

Parametrised asynchronous-serial transmitter and successor to the fixed 8N1, one-bit-per-clock shifter. It adds:
- a clocks-per-bit divider;
- configurable data width and stop-bit count;
- optional parity;
- synchronous reset;
- an explicit busy output.

It sits between a byte producer (ready/ack handshake) and the board TX pin, and is clocked from the 12 MHz system clock.

---
 rtl/serial_tx_frm_pkg.sv | 29 ++
 rtl/serial_tx_frm_if.sv | 17 +
 rtl/serial_tx_frm_baud_div.sv | 35 +++
 rtl/serial_tx_frm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_frm_pkg.sv
// serial_pkg: shared types and helpers for the serial_tx_frm transmitter.
//   tx_state_e   - frame FSM state encoding
//   PAR_BITS     - 1 when SERIAL_TX_PARITY_EN is defined, else 0
//   frame_cycles - clk12 cycles occupied by one frame on the line
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  // Start + data + parity + stop bits, each CLK_DIV cycles long.
  function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                               input int unsigned clk_div,
                                               input int unsigned stop_bits,
                                               input int unsigned par);
    return (32'd1 + data_bits + par + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/serial_tx_frm_if.sv
// serial_tx_frm_if: producer-side word handshake of the serial transmitter.
//   sbyte     - payload word, held stable by the producer until ack
//   sbyte_rdy - producer has a word
//   ack       - transmitter consumed the word this cycle
// Modports: master = byte producer, slave = transmitter.
interface serial_tx_frm_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] sbyte;
  logic                 sbyte_rdy;
  logic                 ack;

  modport master (output sbyte, output sbyte_rdy, input ack);
  modport slave  (input sbyte, input sbyte_rdy, output ack);

endinterface

// File: rtl/serial_tx_frm_baud_div.sv
// serial_baud_div: bit-period timer for the serial transmitter.
//   clk12    - system clock
//   rst      - synchronous reset, active high
//   run      - count while high; count held at 0 while low
//   bit_tick - one-cycle pulse on the last cycle of each bit period
module serial_baud_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk12,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("serial_baud_div: CLK_DIV must be in 1..65535");
  end

  logic [CNT_W-1:0] r_cnt;

  // Terminal compare precedes the increment, so the counter never wraps.
  assign bit_tick = run & (r_cnt == CNT_LAST);

  always_ff @(posedge clk12) begin
    if (rst || !run || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx_frm.sv
// serial_tx_frm: parametrised asynchronous-serial transmitter (LSB first).
//   clk12       - 12 MHz system clock, rising edge
//   rst         - synchronous reset, active high
//   bus         - serial_tx_frm_if.slave: sbyte / sbyte_rdy in, ack out (comb)
//   tx          - registered serial line, idle high
//   busy        - registered, high while a frame is on the line
//   end_of_send - registered one-cycle pulse when a frame completes
// Optional parity bit compiled in with `define SERIAL_TX_PARITY_EN.
module serial_tx_frm
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk12,
  input  logic             rst,
  serial_tx_frm_if.slave   bus,
  output logic             tx,
  output logic             busy,
  output logic             end_of_send
);

  localparam int unsigned BCNT_W    = $clog2(DATA_BITS + 1);
  localparam int unsigned FRAME_CYC = frame_cycles(DATA_BITS, CLK_DIV, STOP_BITS, PAR_BITS);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] STOP_LAST = BCNT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("serial_tx_frm: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("serial_tx_frm: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("serial_tx_frm: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [BCNT_W-1:0]    r_bit_cnt;
  logic [BCNT_W-1:0]    w_bit_cnt_nxt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_eos;
  logic                 w_tx_d;
  logic                 w_busy_d;
  logic                 w_eos_d;
  logic                 w_ack;
  logic                 w_run;
  logic                 w_tick;
  logic [31:0]          r_busy_len;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic r_par;
`endif

  // Accept a word only when idle and not in reset.
  assign w_ack   = bus.sbyte_rdy & ~r_busy & ~rst;
  assign bus.ack = w_ack;
  assign w_run   = (r_state != IDLE);

  serial_baud_div #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk12    (clk12),
    .rst      (rst),
    .run      (w_run),
    .bit_tick (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; every non-idle state advances only on a bit tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_ack) w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
      DATA: begin
        if (w_tick && (r_bit_cnt == DATA_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_state_nxt = PAR;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PAR:   if (w_tick) w_state_nxt = STOP;
`endif
      STOP:  if (w_tick && (r_bit_cnt == STOP_LAST)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next line level, busy and frame-complete pulse, registered below.
  always_comb begin
    w_tx_d   = 1'b1;
    w_busy_d = (w_state_nxt != IDLE);
    w_eos_d  = r_busy & ~w_busy_d;
    case (w_state_nxt)
      START: w_tx_d = 1'b0;
      DATA:  w_tx_d = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      PAR:   w_tx_d = r_par;
`endif
      default: w_tx_d = 1'b1;
    endcase
  end

  // Shift register loads on ack and shifts at each data-bit boundary;
  // bit counter restarts on every state change.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_ack) begin
      w_shift_nxt = bus.sbyte;
    end else if ((r_state == DATA) && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end
    if (w_state_nxt != r_state) begin
      w_bit_cnt_nxt = '0;
    end else if (w_tick && ((r_state == DATA) || (r_state == STOP))) begin
      w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_eos     <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_tx      <= w_tx_d;
      r_busy    <= w_busy_d;
      r_eos     <= w_eos_d;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Payload holding register; contents are meaningless while idle.
  always_ff @(posedge clk12) begin
    r_shift <= w_shift_nxt;
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity computed once from the captured word.
  always_ff @(posedge clk12) begin
    if (w_ack) begin
      r_par <= (^bus.sbyte) ^ PAR_ODD;
    end
  end
`endif

  // Busy-width tracker: a completed frame must span exactly FRAME_CYC cycles.
  always_ff @(posedge clk12) begin
    if (rst || !r_busy) begin
      r_busy_len <= '0;
    end else begin
      r_busy_len <= r_busy_len + 32'd1;
    end
    if (!rst && r_eos) begin
      assert (r_busy_len == FRAME_CYC);
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign end_of_send = r_eos;

endmodule
